// File: rtl/viterbi_frame_if.sv
// viterbi_frame_if: handshake bundle between frame controller, source, encoder and decoder
interface viterbi_frame_if #(
    parameter int FRAME_LEN = 64
) ();
    logic                           start;
    logic                           in_valid;
    logic                           in_data;
    logic                           in_ready;
    logic                           enc_valid;
    logic                           enc_data;
    logic                           dec_valid;
    logic                           dec_data;
    logic                           out_valid;
    logic                           out_data;
    logic                           busy;
    logic                           done;
    logic                           timeout;
    logic [$clog2(FRAME_LEN+1)-1:0] err_count;
    modport master (
        output start, in_valid, in_data, dec_valid, dec_data,
        input  in_ready, enc_valid, enc_data, out_valid, out_data, busy, done, timeout, err_count
    );
    modport slave (
        input  start, in_valid, in_data, dec_valid, dec_data,
        output in_ready, enc_valid, enc_data, out_valid, out_data, busy, done, timeout, err_count
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer feeding the encoder, collecting decoded bits and counting errors
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 6,
    parameter int TIMEOUT   = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    viterbi_frame_if.slave bus_io
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam int WW = $clog2(FRAME_LEN + 1);
    localparam int RW = $clog2(FRAME_LEN + TAIL_LEN + 1);
    localparam int TW = $clog2(TAIL_LEN + 1);
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [RW-1:0] RD_END = RW'(FRAME_LEN + TAIL_LEN);
    typedef enum logic [2:0] {IDLE, LOAD, TAIL, WAIT, DONE} state_e;
    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] bits_q, bits_d;
    logic [WW-1:0]        wr_cnt_q, wr_cnt_d, err_q, err_d;
    logic [RW-1:0]        rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]        tl_cnt_q, tl_cnt_d;
    logic [IW-1:0]        idle_q, idle_d;
    logic                 enc_v_q, enc_v_d, enc_b_q, enc_b_d;
    logic                 out_v_q, out_v_d, out_b_q, out_b_d;
    logic                 to_q, to_d;
    logic                 acc, dec_act, dec_pay;
    always_comb begin
        acc      = state_q == LOAD && bus_io.in_valid;
        dec_act  = (state_q inside {LOAD, TAIL, WAIT}) && bus_io.dec_valid && rd_cnt_q != RD_END;
        dec_pay  = dec_act && rd_cnt_q < RW'(FRAME_LEN);
        state_d  = state_q;
        bits_d   = bits_q;
        wr_cnt_d = acc ? wr_cnt_q + WW'(1) : wr_cnt_q;
        rd_cnt_d = dec_act ? rd_cnt_q + RW'(1) : rd_cnt_q;
        err_d    = err_q + WW'(dec_pay && bus_io.dec_data != bits_q[rd_cnt_q[AW-1:0]]);
        tl_cnt_d = state_q == TAIL ? tl_cnt_q + TW'(1) : '0;
        idle_d   = state_q == WAIT && !bus_io.dec_valid ? idle_q + IW'(1) : '0;
        to_d     = to_q;
        enc_v_d  = acc || state_q == TAIL;
        enc_b_d  = acc && bus_io.in_data;
        out_v_d  = dec_pay;
        out_b_d  = dec_pay && bus_io.dec_data;
        if (acc) bits_d[wr_cnt_q[AW-1:0]] = bus_io.in_data;
        case (state_q)
            IDLE: if (bus_io.start) begin
                state_d  = LOAD;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                err_d    = '0;
                to_d     = 1'b0;
            end
            LOAD: if (acc && wr_cnt_q == WW'(FRAME_LEN - 1)) state_d = TAIL;
            TAIL: if (tl_cnt_q == TW'(TAIL_LEN - 1)) state_d = WAIT;
            WAIT: if (rd_cnt_d == RD_END) state_d = DONE;
                  else if (idle_q == IW'(TIMEOUT - 1)) begin
                      to_d    = 1'b1;
                      state_d = DONE;
                  end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bits_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= '0;
            tl_cnt_q <= '0;
            idle_q   <= '0;
            enc_v_q  <= 1'b0;
            enc_b_q  <= 1'b0;
            out_v_q  <= 1'b0;
            out_b_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bits_q   <= bits_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
            tl_cnt_q <= tl_cnt_d;
            idle_q   <= idle_d;
            enc_v_q  <= enc_v_d;
            enc_b_q  <= enc_b_d;
            out_v_q  <= out_v_d;
            out_b_q  <= out_b_d;
            to_q     <= to_d;
        end
    end
    assign bus_io.in_ready  = state_q == LOAD;
    assign bus_io.busy      = state_q inside {LOAD, TAIL, WAIT};
    assign bus_io.done      = state_q == DONE;
    assign bus_io.enc_valid = enc_v_q;
    assign bus_io.enc_data  = enc_b_q;
    assign bus_io.out_valid = out_v_q;
    assign bus_io.out_data  = out_b_q;
    assign bus_io.timeout   = to_q;
    assign bus_io.err_count = err_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed frames against an echoing decoder stub with queued expectations
module tb_viterbi_frame_ctrl;
    localparam int FL = 64, TL = 6, TO = 1024;
    typedef struct {int due; logic v; logic d;} enc_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0, compared = 0, mismatched = 0;
    int   enc_beats = 0, out_beats = 0, done_cnt = 0, stub_beat = 0;
    bit   dec_en = 1'b1, flip_en = 1'b0;
    enc_t enc_q[$];
    enc_t mon_e;
    logic out_q[$];
    logic mon_b;
    viterbi_frame_if #(.FRAME_LEN(FL)) bus ();
    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    // decoder stub: echoes each encoder beat back, optionally corrupting payload beats 3 and 40
    always @(negedge clk) begin
        bus.dec_valid = dec_en && bus.enc_valid;
        bus.dec_data  = bus.enc_data ^ (flip_en && (stub_beat == 3 || stub_beat == 40));
        stub_beat     = !bus.busy ? 0 : stub_beat + int'(bus.enc_valid);
    end
    always @(negedge clk) begin
        while (enc_q.size() > 0 && enc_q[0].due <= cyc) begin
            mon_e = enc_q.pop_front();
            check("enc_beat", 32'({bus.enc_valid, bus.enc_valid & bus.enc_data}), 32'({mon_e.v, mon_e.d}));
        end
        if (bus.enc_valid) enc_beats++;
        if (bus.out_valid) begin
            out_beats++;
            check("out_expected", 32'(out_q.size() > 0), 32'd1);
            if (out_q.size() > 0) begin
                mon_b = out_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(mon_b));
            end
        end
        if (bus.done) done_cnt++;
    end
    task automatic check_zero(input string tag);
        check(tag, 32'({bus.in_ready, bus.enc_valid, bus.enc_data, bus.out_valid, bus.out_data,
                        bus.busy, bus.done, bus.timeout, bus.err_count}), 32'd0);
    endtask
    task automatic drive_frame(input logic [FL-1:0] pat, input int gap, input int beats, input int start_at);
        int   n = 0, i = 0;
        logic v;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("timeout_cleared", 32'(bus.timeout), 32'd0);
        check("err_cleared", 32'(bus.err_count), 32'd0);
        check("in_ready_load", 32'(bus.in_ready), 32'd1);
        while (n < beats) begin
            v            = !(gap > 0 && i % gap == gap - 1);
            bus.in_valid = v;
            bus.in_data  = v & pat[n];
            bus.start    = v && n == start_at;
            enc_q.push_back('{cyc + 1, v, v & pat[n]});
            if (v) begin
                if (dec_en) out_q.push_back(pat[n] ^ (flip_en && (n == 3 || n == 40)));
                n++;
            end
            i++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        bus.start    = 1'b0;
        if (beats == FL) begin
            check("in_ready_tail", 32'(bus.in_ready), 32'd0);
            for (int k = 1; k <= TL + 1; k++) enc_q.push_back('{cyc + k, k <= TL, 1'b0});
        end
    endtask
    task automatic end_frame(input int limit, input int exp_err, input int exp_to, input int exp_outs,
                             input int out0, input int done0, input bit poke, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            if (bus.done) at = cyc;
            else @(negedge clk);
        end
        check("done_seen", 32'(at >= 0), 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("err_count", 32'(bus.err_count), 32'(exp_err));
        check("timeout", 32'(bus.timeout), 32'(exp_to));
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("err_held", 32'(bus.err_count), 32'(exp_err));
        check("out_beats", 32'(out_beats - out0), 32'(exp_outs));
        check("done_count", 32'(done_cnt - done0), 32'd1);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("enc_q_drained", 32'(enc_q.size()), 32'd0);
    endtask
    initial begin
        int             at, o0, d0, e0, exp_at;
        logic [FL-1:0]  pat;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        for (int k = 0; k < FL; k++) pat[k] = (k % 3 == 1);
        o0 = out_beats; d0 = done_cnt;
        drive_frame(pat, 0, FL, -1);
        end_frame(300, 0, 0, FL, o0, d0, 1'b0, at);
        flip_en = 1'b1;
        pat = {$urandom, $urandom};
        o0 = out_beats; d0 = done_cnt;
        drive_frame(pat, 0, FL, -1);
        end_frame(300, 2, 0, FL, o0, d0, 1'b0, at);
        flip_en = 1'b0;
        pat = {$urandom, $urandom};
        o0 = out_beats; d0 = done_cnt;
        drive_frame(pat, 3, FL, -1);
        end_frame(400, 0, 0, FL, o0, d0, 1'b0, at);
        dec_en = 1'b0;
        o0 = out_beats; d0 = done_cnt;
        drive_frame(pat, 0, FL, -1);
        exp_at = cyc + TL + TO;
        end_frame(TO + 100, 0, 1, 0, o0, d0, 1'b0, at);
        check("timeout_done_cycle", 32'(at), 32'(exp_at));
        dec_en = 1'b1;
        pat = {$urandom, $urandom};
        drive_frame(pat, 0, 21, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset_mid_frame");
        out_q.delete();
        o0 = out_beats; d0 = done_cnt;
        drive_frame(pat, 0, FL, -1);
        end_frame(300, 0, 0, FL, o0, d0, 1'b0, at);
        pat = {$urandom, $urandom};
        o0 = out_beats; d0 = done_cnt; e0 = enc_beats;
        drive_frame(pat, 0, FL, 10);
        end_frame(300, 0, 0, FL, o0, d0, 1'b1, at);
        repeat (5) @(negedge clk);
        check("enc_beats_one_frame", 32'(enc_beats - e0), 32'(FL + TL));
        check("busy_ignored_start", 32'(bus.busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
